instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Streaming RV32I instruction encoder and instruction-memory loader. It is the inverse of the core's control/decode path. It accepts symbolic instruction requests (kind, register numbers, immediate) over a valid/ready handshake, range-checks the request, packs it into a 32-bit machine word, and writes the word into instruction memory at consecutive word addresses. It sits between the test or boot sequencer and the instruction-memory write port, and is used to build programs for the CPU without an external assembler.

## Interface
Parameters:
- ADDR_WIDTH, default 8: instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- clear  input  1  synchronous restart of the load address and count.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted on a rising edge when in_valid & in_ready.
- kind  input  4  instruction kind: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 BNE, 10 LUI, 11 JAL, 12 JALR; 13–15 are illegal.
- rd, rs1, rs2  input  5 each  register numbers; fields a kind does not use are ignored.
- imm  input  32  signed immediate (byte offset for branches and jumps); for LUI, the full 32-bit value.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  encoded instruction.
- err  output  1  one-cycle pulse marking a rejected request.
- count  output  ADDR_WIDTH+1  number of words written since reset or clear.
- full  output  1  count == 2**ADDR_WIDTH.

## Operation
- in_ready = ~full & ~clear. It is a combinational function of registered full and the clear input.

Encoding (standard RV32I fields):
- R-type, opcode 0110011:
  - funct3: ADD/SUB 000, AND 111, OR 110, SLT 010.
  - funct7: 0100000 for SUB, 0000000 for all others.
- I-type:
  - ADDI: opcode 0010011, funct3 000.
  - LW: opcode 0000011, funct3 010.
  - JALR: opcode 1100111, funct3 000.
  - imm[11:0] goes in bits 31:20.
- SW: opcode 0100011, funct3 010, imm[11:5] in bits 31:25, imm[4:0] in bits 11:7.
- BEQ/BNE: opcode 1100011, funct3 000/001, fields {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode}.
- LUI: opcode 0110111, {imm[31:12], rd, opcode}.
- JAL: opcode 1101111, {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.

Range checks (any failure, or an illegal kind, rejects the request):
- I-type and SW: -2048 ≤ imm ≤ 2047.
- BEQ/BNE: -4096 ≤ imm ≤ 4094 and imm[0] = 0.
- JAL: -2^20 ≤ imm ≤ 2^20-2 and imm[0] = 0.
- LUI: imm[11:0] = 0.

Accepted requests:
- A legal request produces one write at mem_addr = count[ADDR_WIDTH-1:0]. count then increments.
- A rejected request is consumed: it pulses err, performs no write, and leaves count unchanged.
- The address never wraps. At full, in_ready is low and in_valid is held off indefinitely.

Clear:
- clear sets count = 0 and full = 0 on the next edge.
- No request is accepted in a clear cycle.
- An already-registered write still completes in the cycle after the clear edge, at its original address.

## Timing
- Reset values: in_ready (with clear low) = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0, err = 0, count = 0, full = 0.
- Latency: for a request accepted at edge k, mem_we (or err) and the data and address are registered and valid during the cycle following edge k. Each is a single-cycle pulse.
- Throughput: one request per cycle. Back-to-back accepts produce back-to-back writes at consecutive addresses.
- count and full update at the same edge that launches the write. in_ready therefore drops in the cycle the last word is written.
- mem_wdata and mem_addr hold their last value when mem_we = 0.
- Reset asserted mid-stream clears everything immediately. A pending write is lost and does not occur.

## Test plan
1. ADDI rd=1, rs1=0, imm=5 after reset -> next cycle: mem_we=1, mem_addr=0, mem_wdata=0x00500093; count=1.
2. Back-to-back requests in consecutive cycles:
   - SUB rd=3, rs1=1, rs2=2 -> 0x402081B3 at addr 0.
   - SW rs2=5, rs1=2, imm=8 -> 0x00512423 at addr 1.
   - LUI rd=5, imm=0x12345000 -> 0x123452B7 at addr 2.
   - Required: mem_we high for 3 consecutive cycles, count=3.
3. BNE rs1=1, rs2=0, imm=-8 -> 0xFE009CE3.
4. Rejections, each giving an err pulse, no mem_we and count unchanged:
   - JAL rd=1, imm=3 (odd offset).
   - ADDI imm=2048 (out of range).
   - kind=14 (illegal).
   - Then a legal request, which must write at the unchanged address.
5. ADDR_WIDTH=2:
   - Four legal writes -> full=1, in_ready=0; in_valid held high for 5 cycles produces no writes.
   - Assert clear -> count=0; the next write lands at addr 0.
6. Assert rst in the cycle after an accept -> mem_we stays 0 and count=0. After release, the first write lands at addr 0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Streaming RV32I encoder and instruction-memory loader. It accepts symbolic
//   instruction requests over a valid/ready handshake and range-checks each one.
//   Legal requests are packed into a 32-bit machine word and written to
//   consecutive word addresses. Rejected requests are consumed and flagged.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   clear      synchronous restart of load address and count
//   in_valid   request valid
//   in_ready   request can be accepted (~full & ~clear)
//   kind       instruction kind (0..12 legal, 13..15 illegal)
//   rd/rs1/rs2 register numbers
//   imm        signed immediate (full value for LUI)
//   mem_we     instruction-memory write strobe (one-cycle pulse)
//   mem_addr   word address of the write
//   mem_wdata  encoded instruction
//   err        one-cycle pulse for a rejected request
//   count      words written since reset or clear
//   full       count == 2**ADDR_WIDTH
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            kind,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full
);

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,  K_SUB  = 4'd1,  K_AND = 4'd2,  K_OR  = 4'd3,
    K_SLT  = 4'd4,  K_ADDI = 4'd5,  K_LW  = 4'd6,  K_SW  = 4'd7,
    K_BEQ  = 4'd8,  K_BNE  = 4'd9,  K_LUI = 4'd10, K_JAL = 4'd11,
    K_JALR = 4'd12
  } kind_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  full_q, full_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  err_q, err_d;

  logic signed [31:0] imm_s;
  logic               i_range_ok, b_range_ok, j_range_ok;
  logic               legal;
  logic [31:0]        word;
  logic               accept;

  assign imm_s = imm;

  // Immediate range windows; branch and jump offsets must also be even.
  assign i_range_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign b_range_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
  assign j_range_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];

  assign in_ready = ~full_q & ~clear;
  assign accept   = in_valid & in_ready;

  // Encoder: pack the symbolic request into RV32I fields and decide legality.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (kind)
      K_ADD:  word = {7'b0000000, rs2, rs1, 3'b000, rd, OP_R};
      K_SUB:  word = {7'b0100000, rs2, rs1, 3'b000, rd, OP_R};
      K_AND:  word = {7'b0000000, rs2, rs1, 3'b111, rd, OP_R};
      K_OR:   word = {7'b0000000, rs2, rs1, 3'b110, rd, OP_R};
      K_SLT:  word = {7'b0000000, rs2, rs1, 3'b010, rd, OP_R};
      K_ADDI: begin
        word  = {imm[11:0], rs1, 3'b000, rd, OP_IMM};
        legal = i_range_ok;
      end
      K_LW: begin
        word  = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
        legal = i_range_ok;
      end
      K_JALR: begin
        word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        legal = i_range_ok;
      end
      K_SW: begin
        word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STOR};
        legal = i_range_ok;
      end
      K_BEQ, K_BNE: begin
        word  = {imm[12], imm[10:5], rs2, rs1, (kind == K_BNE) ? 3'b001 : 3'b000,
                 imm[4:1], imm[11], OP_BR};
        legal = b_range_ok;
      end
      K_LUI: begin
        word  = {imm[31:12], rd, OP_LUI};
        legal = (imm[11:0] == 12'd0);
      end
      K_JAL: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        legal = j_range_ok;
      end
      default: legal = 1'b0;
    endcase
  end

  // Next-state: clear wins over everything because in_ready is low during clear.
  // Address and data hold their last value unless a new write is launched.
  always_comb begin
    count_d     = count_q;
    mem_we_d    = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (clear) begin
      count_d = '0;
    end else if (accept) begin
      if (legal) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = count_q[ADDR_WIDTH-1:0];
        mem_wdata_d = word;
        count_d     = count_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    full_d = (count_d == CAPACITY);
  end

  // State register: reset drops any pending write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= full_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign count     = count_q;
  assign full      = full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
//   Bench for instr_encoder_loader. One instance uses the default 8-bit
//   address, a second uses a 2-bit address to reach the full condition quickly.
//   Expected words come from hand-encoded constants and from a reference
//   encoder written with plain field arithmetic.
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        err;
  logic [8:0]  count;
  logic        full;

  logic        clear_b;
  logic        in_valid_b;
  logic        in_ready_b;
  logic [3:0]  kind_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [31:0] imm_b;
  logic        mem_we_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic        err_b;
  logic [2:0]  count_b;
  logic        full_b;

  int checks;
  int failures;

  instr_encoder_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err(err),
    .count(count), .full(full)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .kind(kind_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b), .imm(imm_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .err(err_b),
    .count(count_b), .full(full_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a request onto the 8-bit instance.
  task automatic applyStimulus(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [31:0] i, input logic v);
    kind     = k;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = i;
    in_valid = v;
  endtask

  function automatic longint fld(input longint u, input int hi, input int lo);
    return (u / (longint'(1) << lo)) % (longint'(1) << (hi - lo + 1));
  endfunction

  function automatic longint pl(input longint v, input int pos);
    return v * (longint'(1) << pos);
  endfunction

  // Reference encoder built from the RV32I field layout with plain arithmetic.
  function automatic void model_encode(input int k, input longint rdv, input longint rs1v,
                                       input longint rs2v, input int immv,
                                       output bit ok, output logic [31:0] w);
    longint u;
    longint acc;
    int     f3;
    u   = longint'(immv) & 64'h0000_0000_FFFF_FFFF;
    ok  = 1'b1;
    acc = 0;
    case (k)
      0, 1, 2, 3, 4: begin
        f3  = (k == 2) ? 7 : (k == 3) ? 6 : (k == 4) ? 2 : 0;
        acc = pl((k == 1) ? 32 : 0, 25) + pl(rs2v, 20) + pl(rs1v, 15) + pl(f3, 12) + pl(rdv, 7) + 51;
      end
      5, 6, 12: begin
        ok  = (immv >= -2048) && (immv <= 2047);
        f3  = (k == 6) ? 2 : 0;
        acc = pl(fld(u, 11, 0), 20) + pl(rs1v, 15) + pl(f3, 12) + pl(rdv, 7) +
              ((k == 5) ? 19 : (k == 6) ? 3 : 103);
      end
      7: begin
        ok  = (immv >= -2048) && (immv <= 2047);
        acc = pl(fld(u, 11, 5), 25) + pl(rs2v, 20) + pl(rs1v, 15) + pl(2, 12) +
              pl(fld(u, 4, 0), 7) + 35;
      end
      8, 9: begin
        ok  = (immv >= -4096) && (immv <= 4094) && (fld(u, 0, 0) == 0);
        acc = pl(fld(u, 12, 12), 31) + pl(fld(u, 10, 5), 25) + pl(rs2v, 20) + pl(rs1v, 15) +
              pl((k == 9) ? 1 : 0, 12) + pl(fld(u, 4, 1), 8) + pl(fld(u, 11, 11), 7) + 99;
      end
      10: begin
        ok  = (fld(u, 11, 0) == 0);
        acc = pl(fld(u, 31, 12), 12) + pl(rdv, 7) + 55;
      end
      11: begin
        ok  = (immv >= -1048576) && (immv <= 1048574) && (fld(u, 0, 0) == 0);
        acc = pl(fld(u, 20, 20), 31) + pl(fld(u, 10, 1), 21) + pl(fld(u, 11, 11), 20) +
              pl(fld(u, 19, 12), 12) + pl(rdv, 7) + 111;
      end
      default: ok = 1'b0;
    endcase
    w = acc[31:0];
  endfunction

  function automatic int rand_imm();
    int bounds[15] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                       -1048576, -1048578, 1048574, 1048576, 0, 1};
    int sel;
    sel = int'($urandom_range(0, 4));
    case (sel)
      0:       return int'($urandom_range(0, 10000)) - 5000;
      1:       return int'($urandom);
      2:       return bounds[$urandom_range(0, 14)];
      3:       return int'($urandom) & 32'hFFFF_F000;
      default: return int'($urandom_range(0, 4194304)) - 2097152;
    endcase
  endfunction

  vec_t        vecs[14];
  int          exp_cnt;
  logic [7:0]  last_addr;
  logic [31:0] last_word;
  int          m_count;
  bit          ok;
  logic [31:0] w;
  bit          exp_rdy;
  bit          acc_now;
  bit          e_we;
  bit          e_err;

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{4'd1,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 32'h402081B3};
    vecs[1]  = '{4'd7,  5'd0, 5'd2, 5'd5, 32'd8,         1'b0, 32'h00512423};
    vecs[2]  = '{4'd10, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h123452B7};
    vecs[3]  = '{4'd9,  5'd0, 5'd1, 5'd0, -32'sd8,       1'b0, 32'hFE009CE3};
    vecs[4]  = '{4'd11, 5'd1, 5'd0, 5'd0, 32'd3,         1'b1, 32'h0};
    vecs[5]  = '{4'd5,  5'd1, 5'd0, 5'd0, 32'd2048,      1'b1, 32'h0};
    vecs[6]  = '{4'd14, 5'd1, 5'd2, 5'd3, 32'd0,         1'b1, 32'h0};
    vecs[7]  = '{4'd5,  5'd2, 5'd3, 5'd0, -32'sd2048,    1'b0, 32'h80018113};
    vecs[8]  = '{4'd8,  5'd0, 5'd1, 5'd2, 32'd4094,      1'b0, 32'h7E208FE3};
    vecs[9]  = '{4'd8,  5'd0, 5'd1, 5'd2, 32'd4096,      1'b1, 32'h0};
    vecs[10] = '{4'd11, 5'd0, 5'd0, 5'd0, -32'sd1048576, 1'b0, 32'h8000006F};
    vecs[11] = '{4'd10, 5'd1, 5'd0, 5'd0, 32'h1234_5001, 1'b1, 32'h0};
    vecs[12] = '{4'd12, 5'd1, 5'd5, 5'd0, 32'd2047,      1'b0, 32'h7FF280E7};
    vecs[13] = '{4'd2,  5'd1, 5'd2, 5'd3, 32'd0,         1'b0, 32'h003170B3};

    rst        = 1'b0;
    clear      = 1'b0;
    clear_b    = 1'b0;
    in_valid_b = 1'b0;
    kind_b     = '0;
    rd_b       = '0;
    rs1_b      = '0;
    rs2_b      = '0;
    imm_b      = '0;
    applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_full", full, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First ADDI after reset.
    applyStimulus(4'd5, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("addi_we", mem_we, 1);
    checkOutput("addi_addr", mem_addr, 0);
    checkOutput("addi_wdata", mem_wdata, 32'h00500093);
    checkOutput("addi_count", count, 1);

    // Restart the load address before the table.
    clear = 1'b1;
    #1;
    checkOutput("clear_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    checkOutput("clear_count", count, 0);
    checkOutput("clear_we", mem_we, 0);

    // Table, applied back to back.
    exp_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d_we", i), mem_we, !vecs[i].exp_err);
      if (!vecs[i].exp_err) begin
        checkOutput($sformatf("vec%0d_addr", i), mem_addr, exp_cnt);
        checkOutput($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_word);
        last_addr = exp_cnt[7:0];
        last_word = vecs[i].exp_word;
        exp_cnt++;
      end
      checkOutput($sformatf("vec%0d_count", i), count, exp_cnt);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("table_idle_we", mem_we, 0);
    checkOutput("table_idle_addr", mem_addr, last_addr);
    checkOutput("table_idle_wdata", mem_wdata, last_word);

    // Randomized stream against the reference encoder.
    m_count = exp_cnt;
    for (int c = 0; c < 700; c++) begin
      applyStimulus(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                    32'(rand_imm()), ($urandom_range(0, 3) != 0));
      clear = ($urandom_range(0, 49) == 0);
      #1;
      exp_rdy = (m_count != 256) && !clear;
      checkOutput("rnd_ready", in_ready, exp_rdy);
      acc_now = in_valid && exp_rdy;
      model_encode(int'(kind), longint'(rd), longint'(rs1), longint'(rs2), int'($signed(imm)), ok, w);
      e_we  = acc_now && ok;
      e_err = acc_now && !ok;
      if (e_we) begin
        last_addr = m_count[7:0];
        last_word = w;
        m_count++;
      end
      if (clear) m_count = 0;
      @(posedge clk);
      #1;
      checkOutput("rnd_we", mem_we, e_we);
      checkOutput("rnd_err", err, e_err);
      checkOutput("rnd_addr", mem_addr, last_addr);
      checkOutput("rnd_wdata", mem_wdata, last_word);
      checkOutput("rnd_count", count, m_count);
      checkOutput("rnd_full", full, m_count == 256);
    end
    in_valid = 1'b0;
    clear    = 1'b0;

    // Small instance: fill to capacity, stall, then clear.
    for (int i = 0; i < 4; i++) begin
      kind_b     = 4'd5;
      rd_b       = 5'(i + 1);
      rs1_b      = 5'd0;
      rs2_b      = 5'd0;
      imm_b      = 32'(i * 3);
      in_valid_b = 1'b1;
      model_encode(5, longint'(i + 1), 0, 0, i * 3, ok, w);
      @(posedge clk);
      #1;
      checkOutput($sformatf("b_fill%0d_we", i), mem_we_b, 1);
      checkOutput($sformatf("b_fill%0d_addr", i), mem_addr_b, i);
      checkOutput($sformatf("b_fill%0d_wdata", i), mem_wdata_b, w);
      checkOutput($sformatf("b_fill%0d_count", i), count_b, i + 1);
    end
    checkOutput("b_full", full_b, 1);
    checkOutput("b_full_ready", in_ready_b, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("b_stall%0d_we", i), mem_we_b, 0);
      checkOutput($sformatf("b_stall%0d_err", i), err_b, 0);
      checkOutput($sformatf("b_stall%0d_count", i), count_b, 4);
    end
    clear_b = 1'b1;
    @(posedge clk);
    #1;
    clear_b = 1'b0;
    checkOutput("b_clear_count", count_b, 0);
    checkOutput("b_clear_full", full_b, 0);
    #1;
    checkOutput("b_clear_ready", in_ready_b, 1);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    checkOutput("b_after_clear_we", mem_we_b, 1);
    checkOutput("b_after_clear_addr", mem_addr_b, 0);
    checkOutput("b_after_clear_count", count_b, 1);

    // Reset right after an accept loses the pending write.
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    applyStimulus(4'd0, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    checkOutput("midrst_we", mem_we, 0);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_full", full, 0);
    @(posedge clk);
    #1;
    checkOutput("midrst_we_hold", mem_we, 0);
    rst = 1'b1;
    applyStimulus(4'd4, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1);
    model_encode(4, 7, 8, 9, 0, ok, w);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("postrst_we", mem_we, 1);
    checkOutput("postrst_addr", mem_addr, 0);
    checkOutput("postrst_wdata", mem_wdata, w);
    checkOutput("postrst_count", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
